// File: rtl/siso_byte_arbiter.sv
// Two-requester round-robin front end feeding one LSB-first parallel-to-serial shift chain.
// Optional even-parity trailer bit is enabled by defining SISO_PARITY_EN.
module siso_byte_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] I0,
  input  logic             I0_valid,
  output logic             I0_ready,
  input  logic [WIDTH-1:0] I1,
  input  logic             I1_valid,
  output logic             I1_ready,
  output logic             O,
  output logic             O_valid,
  input  logic             O_ready,
  output logic             O_first,
  output logic             O_last,
  output logic             grant,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

`ifdef SISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             grant_q;
  logic             win;
  logic             any_valid;
  logic             accept;
`ifdef SISO_PARITY_EN
  logic             parity;
`endif

  // On a tie the requester that did not own the previous frame wins.
  always_comb begin
    win = 1'b0;
    if (I0_valid && I1_valid) win = ~last;
    else if (I1_valid)        win = 1'b1;
  end

  assign any_valid = I0_valid | I1_valid;
  assign accept    = (state == IDLE) && !RESET && any_valid;
  assign I0_ready  = accept && !win;
  assign I1_ready  = accept && win;
  assign grant     = grant_q;
  assign busy      = (state != IDLE);

  always_comb begin
    O       = 1'b0;
    O_valid = 1'b0;
    O_first = 1'b0;
    O_last  = 1'b0;
    case (state)
      SHIFT: begin
        O       = sreg[0];
        O_valid = 1'b1;
        O_first = (cnt == '0);
`ifndef SISO_PARITY_EN
        O_last  = (cnt == CNT_MAX);
`endif
      end
`ifdef SISO_PARITY_EN
      PAR: begin
        O       = parity;
        O_valid = 1'b1;
        O_last  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // cnt returns to 0 when the data phase ends so it never passes WIDTH-1.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      sreg    <= '0;
      cnt     <= '0;
      last    <= 1'b1;
      grant_q <= 1'b0;
`ifdef SISO_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            sreg    <= win ? I1 : I0;
            grant_q <= win;
            last    <= win;
            cnt     <= '0;
            state   <= SHIFT;
`ifdef SISO_PARITY_EN
            parity  <= win ? ^I1 : ^I0;
`endif
          end
        end
        SHIFT: begin
          if (O_ready) begin
            sreg <= {1'b0, sreg[WIDTH-1:1]};
            if (cnt == CNT_MAX) begin
              cnt <= '0;
`ifdef SISO_PARITY_EN
              state <= PAR;
`else
              state <= IDLE;
`endif
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
`ifdef SISO_PARITY_EN
        PAR: begin
          if (O_ready) state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/siso_byte_arbiter.md
# siso_byte_arbiter

Two-requester round-robin scheduler that shares one serial-in/serial-out shift chain for parallel-to-serial transmission. It accepts a WIDTH-bit word from the granted requester over a valid/ready handshake and loads it into an internal WIDTH-stage register chain. It then shifts the word out LSB-first, one bit per enabled cycle, under downstream backpressure. It sits between parallel word producers and a single-bit serial link.

## Interface
- WIDTH, 8, word length and number of shift stages; legal range 2..32.

- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- I0  in  WIDTH  requester 0 data word.
- I0_valid  in  1  requester 0 has a word.
- I0_ready  out  1  requester 0 word accepted this cycle when high together with I0_valid.
- I1  in  WIDTH  requester 1 data word.
- I1_valid  in  1  requester 1 has a word.
- I1_ready  out  1  requester 1 handshake ready.
- O  out  1  serial output bit.
- O_valid  out  1  O carries a frame bit.
- O_ready  in  1  downstream consumes O this cycle; low stalls the shift.
- O_first  out  1  current bit is bit 0 of the frame.
- O_last  out  1  current bit is the final bit of the frame.
- grant  out  1  index of the requester that owns the current or most recent frame.
- busy  out  1  a frame is in flight (state not IDLE).

## Operation
- States: IDLE, SHIFT, plus PAR when SISO_PARITY_EN is defined.
- IDLE:
  - Arbitration is combinational from the valids and the `last` pointer.
  - If only one valid is high, that requester wins.
  - If both are high, the requester not equal to `last` wins.
  - The winner's ready is high. The loser's ready is low.
  - If no valid is high, both readies are low.
  - On a handshake: load the winner's word into the shift register, set grant and `last` to the winner, clear `cnt` to 0, and go to SHIFT.
- SHIFT:
  - O = sreg[0] and O_valid = 1.
  - O_first = (cnt == 0). O_last = (cnt == WIDTH-1), but only when parity is disabled.
  - When O_ready is high: shift sreg right with 0 filling the MSB, and increment cnt.
  - If O_ready is high and cnt == WIDTH-1: go to IDLE (parity disabled) or to PAR (parity enabled).
  - When O_ready is low: sreg, cnt and O are held.
- Both readies are low in every state other than IDLE.
- cnt width is clog2(WIDTH). cnt never exceeds WIDTH-1.
- The `last` pointer changes only on a handshake.

## Timing
- Reset values (RESET high at a rising edge):
  - state IDLE, sreg 0, cnt 0, `last` = 1 so requester 0 has first priority.
  - O 0, O_valid 0, O_first 0, O_last 0, grant 0, busy 0.
  - I0_ready and I1_ready are forced to 0 while RESET is high.
- RESET high mid-frame aborts the frame. No further bits are emitted, and the next cycle is IDLE.
- Latency: a handshake at edge k puts bit 0 on O with O_valid during cycle k+1.
- With O_ready held high, a frame occupies WIDTH cycles (WIDTH+1 with parity).
- There is one mandatory IDLE cycle between frames, so peak throughput is one word per WIDTH+1 cycles (WIDTH+2 with parity).
- The valid/ready handshake is standard:
  - valid is not withdrawn before the handshake.
  - ready may depend combinationally on valid.
  - No combinational path exists from O_ready to I*_ready.
- A valid that rises while busy waits. It is arbitrated in the next IDLE cycle.

## Configuration
- SISO_PARITY_EN defined:
  - After data bit WIDTH-1 is consumed, state PAR drives O = even parity (XOR of the loaded word) with O_valid = 1 and O_last = 1.
  - PAR holds while O_ready is low and goes to IDLE when O_ready is high.
  - The parity bit is captured at load time.
- SISO_PARITY_EN undefined:
  - No PAR state and no parity register.
  - O_last is asserted on data bit WIDTH-1.

## Test plan
- Single word: reset, then I0 = 8'hA5 with I0_valid and O_ready held high. Required: I0_ready high for one cycle; O = 1,0,1,0,0,1,0,1 over 8 cycles; O_first on bit 0; O_last on bit 7 (on the parity bit, 0, with the macro); grant = 0.
- Contention: I0_valid and I1_valid high continuously after reset, with I0 = 8'h01 and I1 = 8'h80. Required: grant sequence 0,1,0,1; each frame matches its source word; exactly one IDLE cycle between frames.
- Backpressure: O_ready low for 3 cycles in the middle of frame 8'h3C at cnt = 4. Required: O, cnt and O_last held; frame still completes with the correct bit order; total duration 8+3 cycles.
- Reset mid-frame: RESET asserted at cnt = 5. Required: the next cycle has O_valid 0, busy 0, grant 0; the next I1 word is granted with no I0 pending; requester 0 wins first in a subsequent tie.
- No request: valids low for 20 cycles. Required: O_valid 0, busy 0, both readies 0; `last` unchanged.
- Parity (macro defined): word 8'h07. Required: 9-bit frame whose parity bit is 1, with O_last asserted only on the parity bit; with the macro undefined, an 8-bit frame.
